// File: rtl/pdm_fade_sequencer.sv
// PDM brightness sequencer: per-channel fades stepped once per frame and merged with host writes
// onto one bank write port. Define PDM_SEQ_GAMMA_EN for a square-law pdm_value mapping.
module pdm_fade_lane #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             host_we,
    input  logic             host_mode,
    input  logic [WIDTH-1:0] host_value,
    input  logic             step_en,
    output logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] tgt
);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur <= '0;
            tgt <= '0;
        end else if (host_we) begin
            tgt <= host_value;
            if (!host_mode) cur <= host_value;
        end else if (step_en) begin
            // Steps only toward the target, so a level can never wrap.
            if (cur < tgt)      cur <= cur + WIDTH'(1);
            else if (cur > tgt) cur <= cur - WIDTH'(1);
        end
    end
endmodule

module pdm_fade_sequencer #(
    parameter int CHANNELS   = 8,
    parameter int WIDTH      = 5,
    parameter int FRAME_LOG2 = 6,
    localparam int CW        = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             host_wr_en,
    input  logic [CW-1:0]    host_ch,
    input  logic [WIDTH-1:0] host_value,
    input  logic             host_mode,
    output logic             host_ack,
    output logic             pdm_wr_en,
    output logic [CW-1:0]    pdm_ch,
    output logic [WIDTH-1:0] pdm_value,
    output logic             frame_tick,
    output logic             busy
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t                         state;
    logic [CW-1:0]                  idx;
    logic                           pending;
    logic [FRAME_LOG2-1:0]          fcnt;
    logic [CHANNELS-1:0][WIDTH-1:0] cur, tgt;
    logic [WIDTH-1:0]               cur_sel, tgt_sel, step_val;
    logic                           scan_go;

`ifdef PDM_SEQ_GAMMA_EN
    function automatic logic [WIDTH-1:0] level_map(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] sq;
        sq = (2*WIDTH)'(v) * (2*WIDTH)'(v);
        // Full scale is pinned so the top level still reaches 100% duty.
        return (v == '1) ? v : WIDTH'(sq >> WIDTH);
    endfunction
`else
    function automatic logic [WIDTH-1:0] level_map(input logic [WIDTH-1:0] v);
        return v;
    endfunction
`endif

    assign frame_tick = &fcnt;
    assign busy       = (state == SCAN);
    assign scan_go    = (state == SCAN) && !host_wr_en;
    assign cur_sel    = cur[idx];
    assign tgt_sel    = tgt[idx];
    assign step_val   = (cur_sel < tgt_sel) ? cur_sel + WIDTH'(1) : cur_sel - WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pdm_fade_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .host_we   (host_wr_en && (host_ch == CW'(i))),
            .host_mode (host_mode),
            .host_value(host_value),
            .step_en   (scan_go && (idx == CW'(i))),
            .cur       (cur[i]),
            .tgt       (tgt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            fcnt      <= '0;
            host_ack  <= 1'b0;
            pdm_wr_en <= 1'b0;
            pdm_ch    <= '0;
            pdm_value <= '0;
        end else begin
            fcnt      <= fcnt + FRAME_LOG2'(1);
            host_ack  <= host_wr_en;
            pdm_wr_en <= 1'b0;
            // Host always owns the write port; the scan simply holds its index.
            if (host_wr_en && !host_mode) begin
                pdm_wr_en <= 1'b1;
                pdm_ch    <= host_ch;
                pdm_value <= level_map(host_value);
            end else if (scan_go && (cur_sel != tgt_sel)) begin
                pdm_wr_en <= 1'b1;
                pdm_ch    <= idx;
                pdm_value <= level_map(step_val);
            end
            case (state)
                IDLE: if (frame_tick || pending) begin
                    state   <= SCAN;
                    idx     <= '0;
                    pending <= 1'b0;
                end
                SCAN: begin
                    if (frame_tick) pending <= 1'b1;
                    if (!host_wr_en) begin
                        idx <= idx + CW'(1);
                        if (idx == CW'(CHANNELS - 1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdm_fade_sequencer.sv
// Bench for pdm_fade_sequencer: per-cycle compare against a frame/scan model plus directed literal checks.
module tb_pdm_fade_sequencer;
    localparam int CH    = 8;
    localparam int W     = 5;
    localparam int FL    = 6;
    localparam int FRAME = 1 << FL;
    localparam int CW    = $clog2(CH);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          host_wr_en = 1'b0;
    logic [CW-1:0] host_ch = '0;
    logic [W-1:0]  host_value = '0;
    logic          host_mode = 1'b0;
    logic          host_ack, pdm_wr_en, frame_tick, busy;
    logic [CW-1:0] pdm_ch;
    logic [W-1:0]  pdm_value;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_on = 0;

    pdm_fade_sequencer #(.CHANNELS(CH), .WIDTH(W), .FRAME_LOG2(FL)) dut (
        .clk(clk), .reset_n(reset_n), .host_wr_en(host_wr_en), .host_ch(host_ch),
        .host_value(host_value), .host_mode(host_mode), .host_ack(host_ack),
        .pdm_wr_en(pdm_wr_en), .pdm_ch(pdm_ch), .pdm_value(pdm_value),
        .frame_tick(frame_tick), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int disp(input int v);
`ifdef PDM_SEQ_GAMMA_EN
        return (v == (1 << W) - 1) ? v : (v * v) / (1 << W);
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: levels as int arrays, a scan is a walk over positions 0..CH-1, host cycles skip a step.
    int  mcur[CH], mtgt[CH];
    int  fc = 0, pos = 0, hc;
    bit  scanning = 0, pend = 0, tick, was;
    int  e_ack = 0, e_we = 0, e_ch = 0, e_val = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin mcur[i] = 0; mtgt[i] = 0; end
            fc = 0; pos = 0; scanning = 0; pend = 0;
            e_ack = 0; e_we = 0; e_ch = 0; e_val = 0;
        end else begin
            tick = (fc == FRAME - 1);
            was  = scanning;
            e_ack = 0; e_we = 0;
            if (host_wr_en) begin
                hc = int'(host_ch);
                e_ack = 1;
                mtgt[hc] = int'(host_value);
                if (!host_mode) begin
                    mcur[hc] = int'(host_value);
                    e_we = 1; e_ch = hc; e_val = disp(mcur[hc]);
                end
            end
            if (!was) begin
                if (tick || pend) begin scanning = 1; pos = 0; pend = 0; end
            end else begin
                if (tick) pend = 1;
                if (!host_wr_en) begin
                    if (mcur[pos] != mtgt[pos]) begin
                        mcur[pos] = mcur[pos] + ((mcur[pos] < mtgt[pos]) ? 1 : -1);
                        e_we = 1; e_ch = pos; e_val = disp(mcur[pos]);
                    end
                    pos++;
                    if (pos == CH) scanning = 0;
                end
            end
            fc = (fc + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("host_ack", int'(host_ack), e_ack);
            chk("pdm_wr_en", int'(pdm_wr_en), e_we);
            chk("pdm_ch", int'(pdm_ch), e_ch);
            chk("pdm_value", int'(pdm_value), e_val);
            chk("frame_tick", int'(frame_tick), (fc == FRAME - 1) ? 1 : 0);
            chk("busy", int'(busy), int'(scanning));
        end
    end

    task automatic host_write(input int ch, input int val, input bit mode);
        host_wr_en = 1'b1; host_ch = CW'(ch); host_value = W'(val); host_mode = mode;
        @(negedge clk);
        host_wr_en = 1'b0;
    endtask

    // Leaves the bench at a negedge in the cycle where frame_tick is high.
    task automatic wait_tick();
        int k;
        k = 0;
        while (!frame_tick && k < 3 * FRAME) begin @(negedge clk); k++; end
        if (!frame_tick) chk("wait_tick_timeout", 0, 1);
    endtask

    task automatic sync_idle();
        wait_tick();
        repeat (16) @(negedge clk);
    endtask

    initial begin
        int k, n, ev, last_tick, nb;

        // Reset and first frame
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_wr_en", int'(pdm_wr_en), 0);
        chk("rst_value", int'(pdm_value), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        k = 0;
        while (!frame_tick && k < 200) begin @(negedge clk); k++; end
        chk("first_tick_cycle", k, 63);
        n = 0;
        repeat (2 * FRAME) begin @(negedge clk); if (pdm_wr_en) n++; end
        chk("idle_writes", n, 0);

        // Immediate host write
        sync_idle();
        host_write(2, 8, 1'b0);
        chk("m0_ack", int'(host_ack), 1);
        chk("m0_we", int'(pdm_wr_en), 1);
        chk("m0_ch", int'(pdm_ch), 2);
`ifdef PDM_SEQ_GAMMA_EN
        chk("m0_val", int'(pdm_value), 2);
`else
        chk("m0_val", int'(pdm_value), 8);
`endif

        // Fade ch0 from 0x08 to 0x1a, one LSB per frame at T+2
        sync_idle();
        host_write(0, 8, 1'b0);
        host_write(0, 26, 1'b1);
        chk("m1_no_write", int'(pdm_wr_en), 0);
        n = 0; ev = 9; last_tick = -1000;
        repeat (20 * FRAME) begin
            @(negedge clk);
            if (frame_tick) last_tick = cyc;
            if (pdm_wr_en) begin
                chk("fade_ch", int'(pdm_ch), 0);
                chk("fade_val", int'(pdm_value), disp(ev));
                chk("fade_latency", cyc - last_tick, 2);
                ev++; n++;
            end
        end
        chk("fade_count", n, 18);

        // Host writes stall a running scan
        sync_idle();
        host_write(0, 0, 1'b1);
        host_write(1, 31, 1'b1);
        host_write(2, 31, 1'b1);
        host_write(3, 31, 1'b1);
        wait_tick();
        chk("stall_busy_T", int'(busy), 0);
        nb = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (busy) nb++;
            if (j >= 2 && j <= 5) begin
                chk("stall_ack", int'(host_ack), 1);
                chk("stall_ch", int'(pdm_ch), 4 + j - 2);
                chk("stall_val", int'(pdm_value), disp(j + 9));
            end
            if (j == 6) begin
                chk("resume_we", int'(pdm_wr_en), 1);
                chk("resume_ch", int'(pdm_ch), 0);
                chk("resume_val", int'(pdm_value), disp(25));
            end
            if (j <= 4) begin
                host_wr_en = 1'b1; host_ch = CW'(4 + j - 1); host_value = W'(j + 10); host_mode = 1'b0;
            end else begin
                host_wr_en = 1'b0;
            end
        end
        chk("stall_busy_cycles", nb, 12);

        // Reset while the scan sits on idx 3
        wait_tick();
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_we", int'(pdm_wr_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ch", int'(pdm_ch), 0);
        chk("abort_val", int'(pdm_value), 0);
        reset_n = 1'b1;
        n = 0;
        repeat (2 * FRAME + 4) begin @(negedge clk); if (pdm_wr_en) n++; end
        chk("post_rst_writes", n, 0);

        // Output mapping
        sync_idle();
        host_write(5, 15, 1'b0);
`ifdef PDM_SEQ_GAMMA_EN
        chk("map_0f", int'(pdm_value), 7);
`else
        chk("map_0f", int'(pdm_value), 15);
`endif
        host_write(5, 4, 1'b0);
`ifdef PDM_SEQ_GAMMA_EN
        chk("map_04", int'(pdm_value), 0);
`else
        chk("map_04", int'(pdm_value), 4);
`endif
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
